// File: rtl/serializer_pkg.sv
// Shared types and constants for the packet serializer: packet layout, frame
// geometry, idle-slot value and the buffer state encoding.
package serializer_pkg;

  typedef struct packed {
    logic [7:0] head;
    logic [7:0] dst;
    logic [7:0] pay;
    logic [7:0] crc;
  } packet_in_t;

  localparam int FRAME_BITS = 32;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  localparam packet_in_t IDLE_PKT = '0;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_e;

  function automatic logic is_last_bit(input logic [CNT_W-1:0] cnt);
    return cnt == CNT_W'(FRAME_BITS - 1);
  endfunction

  // The frame counter wraps straight from the last bit to bit 0, no gap.
  function automatic logic [CNT_W-1:0] next_bit(input logic [CNT_W-1:0] cnt);
    return is_last_bit(cnt) ? '0 : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/serializer_twophase_slave.sv
// Two-phase (toggle) handshake slave: flags a pending request whenever req
// differs from the last accepted level and toggles ack once per accept.
module twophase_slave (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic take_i,
  output logic pending_o,
  output logic ack_o
);

  logic req_seen_q, req_seen_d;
  logic ack_q, ack_d;
  logic accept;

  assign pending_o = req_i ^ req_seen_q;
  // Gate with pending so a stray take can never produce an extra ack toggle.
  assign accept    = take_i & pending_o;

  always_comb begin
    req_seen_d = req_seen_q;
    ack_d      = ack_q;
    if (accept) begin
      req_seen_d = req_i;
      ack_d      = ~ack_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_seen_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      req_seen_q <= req_seen_d;
      ack_q      <= ack_d;
    end
  end

  assign ack_o = ack_q;

endmodule

// File: rtl/serializer.sv
// Packet serializer: buffers one packet from a two-phase source and sends it
// LSB first in the next fixed 32-cycle frame slot; empty slots carry IDLE_PKT.
module serializer
  import serializer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       src2ser_req,
  input  packet_in_t src2ser_data,
  output logic       src2ser_ack,
  output logic       dout,
  output logic       frame_start,
  output logic       pkt_sent
);

  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  buf_state_e            state_q, state_d;
  packet_in_t            pkt_buf_q, pkt_buf_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic                  pkt_sent_q, pkt_sent_d;
  logic                  boundary;
  logic                  pending;
  logic                  take;

  twophase_slave u_hs (
    .clk       (clk),
    .rst       (rst),
    .req_i     (src2ser_req),
    .take_i    (take),
    .pending_o (pending),
    .ack_o     (src2ser_ack)
  );

  assign boundary = is_last_bit(bit_cnt_q);

  // Buffer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a boundary always drains the buffer, a take always fills it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (pending) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (boundary && !pending) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Accept when the buffer is free, or frees up on this very edge.
  always_comb begin
    take = 1'b0;
    unique case (state_q)
      ST_EMPTY: take = pending;
      ST_FULL:  take = pending & boundary;
      default:  take = 1'b0;
    endcase
  end

  always_comb begin
    bit_cnt_d  = next_bit(bit_cnt_q);
    pkt_buf_d  = take ? src2ser_data : pkt_buf_q;
    pkt_sent_d = boundary && (state_q == ST_FULL);
    shreg_d    = {1'b0, shreg_q[FRAME_BITS-1:1]};
    if (boundary) begin
      shreg_d = (state_q == ST_FULL) ? pkt_buf_q : IDLE_PKT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q  <= '0;
      shreg_q    <= IDLE_PKT;
      pkt_sent_q <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      pkt_sent_q <= pkt_sent_d;
    end
  end

  // Buffer contents are meaningful only while FULL, so they need no reset.
  always_ff @(posedge clk) begin
    pkt_buf_q <= pkt_buf_d;
  end

  assign dout        = shreg_q[0];
  assign frame_start = (bit_cnt_q == '0);
  assign pkt_sent    = pkt_sent_q;

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: frame-slot reference model plus
// directed scenarios and a randomized 500-packet scoreboard run.
module tb_serializer;
  import serializer_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       src2ser_req = 1'b0;
  packet_in_t src2ser_data = '0;
  logic       src2ser_ack;
  logic       dout;
  logic       frame_start;
  logic       pkt_sent;

  serializer dut (
    .clk          (clk),
    .rst          (rst),
    .src2ser_req  (src2ser_req),
    .src2ser_data (src2ser_data),
    .src2ser_ack  (src2ser_ack),
    .dout         (dout),
    .frame_start  (frame_start),
    .pkt_sent     (pkt_sent)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: time since reset decides frame/bit; each frame slot holds
  // at most one packet; an accept at bit b of frame k targets frame k+1,
  // except an accept on the last bit, which targets frame k+2.
  int          m_t     = 0;
  bit          m_valid = 1'b0;
  logic        m_seen  = 1'b0;
  logic        m_ack   = 1'b0;
  logic [31:0] m_frame [int];

  always @(posedge clk) begin
    if (rst) begin
      m_t = 0;
      m_seen = 1'b0;
      m_ack = 1'b0;
      m_frame.delete();
      m_valid = 1'b1;
    end else if (m_valid) begin
      int k, c, tgt;
      k = m_t / 32;
      c = m_t % 32;
      if (src2ser_req != m_seen) begin
        tgt = (c == 31) ? k + 2 : k + 1;
        if (!m_frame.exists(tgt)) begin
          m_frame[tgt] = src2ser_data;
          m_seen = src2ser_req;
          m_ack = ~m_ack;
        end
      end
      m_t++;
    end
  end

  // Per-cycle compare plus frame capture for the directed checks and scoreboard.
  logic [31:0] fw [int];
  bit          fs [int];
  logic [31:0] cur_w = '0;
  bit          cur_s = 1'b0;
  logic        prev_ack = 1'b0;
  int          ack_tog = 0;
  bit          sb_en = 1'b0;
  logic [31:0] rxq [$];
  logic [31:0] txq [$];

  always @(negedge clk) begin
    if (m_valid) begin
      int k, c;
      logic [31:0] exp_pkt;
      bit has;
      k = m_t / 32;
      c = m_t % 32;
      has = m_frame.exists(k);
      exp_pkt = has ? m_frame[k] : 32'h0;
      chk("dout", {31'b0, dout}, {31'b0, exp_pkt[c]});
      chk("frame_start", {31'b0, frame_start}, {31'b0, (c == 0)});
      chk("pkt_sent", {31'b0, pkt_sent}, {31'b0, (c == 0) && has});
      chk("ack", {31'b0, src2ser_ack}, {31'b0, m_ack});
      cur_w[c] = dout;
      if (c == 0) cur_s = pkt_sent;
      if (c == 31) begin
        fw[k] = cur_w;
        fs[k] = cur_s;
        if (sb_en) begin
          if (cur_s) rxq.push_back(cur_w);
          else chk("idle_frame_zero", cur_w, 32'h0);
        end
      end
      if (src2ser_ack !== prev_ack) ack_tog++;
      prev_ack = src2ser_ack;
    end
  end

  function automatic logic [31:0] frame_word(input int k);
    return fw.exists(k) ? fw[k] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] frame_sent(input int k);
    return (fs.exists(k) && fs[k]) ? 32'd1 : 32'd0;
  endfunction

  // Called at a negedge; returns at the negedge where reset state is visible.
  task automatic do_reset();
    rst = 1'b1;
    src2ser_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    fw.delete();
    fs.delete();
    ack_tog = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_t(input int target);
    int n;
    n = 0;
    while (m_t < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (m_t < target) chk("wait_t_timeout", m_t, target);
  endtask

  task automatic wait_bit(input int b);
    int n;
    n = 0;
    while ((m_t % 32) != b && n < 64) begin
      @(negedge clk);
      n++;
    end
    if ((m_t % 32) != b) chk("wait_bit_timeout", m_t % 32, b);
  endtask

  task automatic send(input logic [31:0] w, output int n);
    src2ser_data = packet_in_t'(w);
    src2ser_req = ~src2ser_req;
    n = 0;
    while (src2ser_ack !== src2ser_req && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (src2ser_ack !== src2ser_req) chk("ack_timeout", {31'b0, src2ser_ack}, {31'b0, src2ser_req});
  endtask

  initial begin
    int n, cnt, k0;
    logic dor;
    logic [31:0] w;

    repeat (2) @(negedge clk);

    // Reset state and idle line
    do_reset();
    chk("rst_dout", {31'b0, dout}, 32'd0);
    chk("rst_frame_start", {31'b0, frame_start}, 32'd1);
    chk("rst_pkt_sent", {31'b0, pkt_sent}, 32'd0);
    chk("rst_ack", {31'b0, src2ser_ack}, 32'd0);
    cnt = 0;
    dor = 1'b0;
    for (int i = 0; i < 96; i++) begin
      cnt += int'(frame_start);
      dor |= dout;
      @(negedge clk);
    end
    chk("idle_fs_count", cnt, 3);
    chk("idle_dout_or", {31'b0, dor}, 32'd0);

    // Single packet in frame 0 appears in frame 1
    do_reset();
    wait_cycles(5);
    send(32'hA503_5CE1, n);
    chk("single_ack_latency", n, 1);
    wait_t(64);
    chk("single_frame1", frame_word(1), 32'hA503_5CE1);
    chk("single_sent1", frame_sent(1), 32'd1);
    chk("single_frame0_idle", frame_word(0), 32'h0);

    // Back-to-back: second ack held until the frame boundary
    do_reset();
    wait_cycles(3);
    send(32'h1122_3344, n);
    send(32'hDEAD_BEEF, n);
    chk("b2b_ack_at_boundary", m_t % 32, 0);
    wait_t(96);
    chk("b2b_frame1", frame_word(1), 32'h1122_3344);
    chk("b2b_frame2", frame_word(2), 32'hDEAD_BEEF);

    // Request lands on the last bit while FULL
    do_reset();
    wait_cycles(2);
    send(32'h0BAD_F00D, n);
    wait_bit(31);
    send(32'h5A5A_C3C3, n);
    chk("last_bit_ack_latency", n, 1);
    wait_t(96);
    chk("last_bit_frame1", frame_word(1), 32'h0BAD_F00D);
    chk("last_bit_frame2", frame_word(2), 32'h5A5A_C3C3);
    chk("last_bit_sent2", frame_sent(2), 32'd1);
    chk("last_bit_ack_toggles", ack_tog, 2);

    // Reset mid-frame with a full buffer
    do_reset();
    wait_cycles(2);
    send(32'h1357_9BDF, n);
    wait_bit(17);
    do_reset();
    chk("midrst_dout", {31'b0, dout}, 32'd0);
    chk("midrst_ack", {31'b0, src2ser_ack}, 32'd0);
    wait_t(64);
    chk("midrst_frame0_idle", frame_word(0), 32'h0);
    chk("midrst_frame1_idle", frame_word(1), 32'h0);
    chk("midrst_sent1", frame_sent(1), 32'd0);
    k0 = m_t / 32;
    send(32'h2468_ACE0, n);
    wait_t((k0 + 2) * 32);
    chk("midrst_new_pkt", frame_word(k0 + 1), 32'h2468_ACE0);

    // Randomized gaps, 500 packets
    do_reset();
    sb_en = 1'b1;
    rxq.delete();
    txq.delete();
    for (int i = 0; i < 500; i++) begin
      wait_cycles($urandom_range(0, 40));
      w = $urandom;
      txq.push_back(w);
      send(w, n);
    end
    wait_cycles(100);
    sb_en = 1'b0;
    chk("sb_count", rxq.size(), txq.size());
    for (int i = 0; i < txq.size() && i < rxq.size(); i++) begin
      chk("sb_order", rxq[i], txq[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
